// File: rtl/mem_access_ctrl_if.sv
// Core-side load/store request bus of mem_access_ctrl: request, address/data, busy and read return.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `DATA_WIDTH
);
    logic                  i_ren;
    logic                  i_wen;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_busy;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_rvalid;

    modport master (
        output i_ren, i_wen, i_address, i_data,
        input  o_busy, o_data, o_rvalid
    );

    modport slave (
        input  i_ren, i_wen, i_address, i_data,
        output o_busy, o_data, o_rvalid
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Registered controller between the core load/store port and a synchronous memory (optional MEM_CTRL_WBUF_EN posted-write FIFO).
// Latency: write enable 1 cycle after accept (2 with buffer); read data returns RD_LATENCY+2 cycles after accept.
// Backpressure: o_busy holds the requester while a transfer is in flight; with the buffer, writes stall only when the FIFO is full.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mem_access_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_ctrl_if.slave      bus,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_r_en,
    output logic                  mem_w_en
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;

    localparam int CW = $clog2(RD_LATENCY + 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  o_rvalid_q;

    logic                  wr_go;
    logic                  rd_go;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;

`ifdef MEM_CTRL_WBUF_EN
    localparam int PW = $clog2(WBUF_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           fifo_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PW+1)'(WBUF_DEPTH));
    // Draining the FIFO takes priority over a read, so reads always see earlier writes.
    assign pop        = (state == IDLE) && !fifo_empty;
    assign push       = bus.i_wen && (!fifo_full || pop);
    assign wr_go      = pop;
    assign rd_go      = bus.i_ren && !bus.i_wen && fifo_empty;
    assign wr_addr    = fifo_addr[rd_ptr];
    assign wr_data    = fifo_data[rd_ptr];
    assign busy       = bus.i_wen ? (fifo_full && !pop)
                                  : ((state != IDLE) || !fifo_empty);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.i_address;
            fifo_data[wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + (PW+1)'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - (PW+1)'(1);
        end
    end
`else
    // A simultaneous read is dropped silently; the requester re-presents it.
    assign wr_go   = bus.i_wen;
    assign rd_go   = bus.i_ren;
    assign wr_addr = bus.i_address;
    assign wr_data = bus.i_data;
    assign busy    = (state != IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_w_en   <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_addr   <= '0;
            mem_w_data <= '0;
            o_data_q   <= '0;
            o_rvalid_q <= 1'b0;
        end else begin
            mem_w_en   <= 1'b0;
            mem_r_en   <= 1'b0;
            o_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_go) begin
                        state      <= WRITE;
                        mem_w_en   <= 1'b1;
                        mem_addr   <= wr_addr;
                        mem_w_data <= wr_data;
                    end else if (rd_go) begin
                        state    <= READ;
                        mem_r_en <= 1'b1;
                        mem_addr <= bus.i_address;
                    end
                end
                WRITE: state <= IDLE;
                READ: begin
                    cnt   <= CW'(RD_LATENCY);
                    state <= WAIT;
                end
                WAIT: begin
                    // The final count cycle is the one where mem_r_data is valid.
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        o_data_q   <= mem_r_data;
                        o_rvalid_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy   = busy;
    assign bus.o_data   = o_data_q;
    assign bus.o_rvalid = o_rvalid_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three controllers (RD_LATENCY 1, 3, 4) share one request stream and are checked against a transaction-level model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_mem_access_ctrl;
    localparam int DW = `DATA_WIDTH;
    localparam int AW = `DATA_WIDTH;
    localparam int ND = 3;
    localparam int WD = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ren   = 1'b0;
    logic          wen   = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] data  = '0;
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;

    logic          busy_v [ND];
    logic          rv_v   [ND];
    logic          we_v   [ND];
    logic          re_v   [ND];
    logic [DW-1:0] od_v   [ND];
    logic [DW-1:0] wd_v   [ND];
    logic [AW-1:0] ma_v   [ND];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic logic [DW-1:0] initv(input int i);
        return DW'((i * 257) ^ 32'h5A5A);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        logic [DW-1:0] mem_r_data;
        logic [DW-1:0] mem_w_data;
        logic [AW-1:0] mem_addr;
        logic          mem_r_en;
        logic          mem_w_en;
        logic [DW-1:0] mem  [256];
        logic [DW-1:0] pipe [8];

        assign bus.i_ren     = ren;
        assign bus.i_wen     = wen;
        assign bus.i_address = addr;
        assign bus.i_data    = data;

        mem_access_ctrl #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L), .WBUF_DEPTH(WD)
        ) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus),
            .mem_r_data(mem_r_data), .mem_w_data(mem_w_data), .mem_addr(mem_addr),
            .mem_r_en(mem_r_en), .mem_w_en(mem_w_en)
        );

        // Synchronous memory: data valid L cycles after the enable cycle, junk otherwise.
        assign mem_r_data = pipe[L-1];
        initial for (int i = 0; i < 256; i++) mem[i] = initv(i);
        always @(posedge clk) begin
            pipe[0] <= mem_r_en ? mem[mem_addr[7:0]] : DW'($urandom);
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
            if (mem_w_en) mem[mem_addr[7:0]] = mem_w_data;
        end

        assign busy_v[g] = bus.o_busy;
        assign rv_v[g]   = bus.o_rvalid;
        assign od_v[g]   = bus.o_data;
        assign we_v[g]   = mem_w_en;
        assign re_v[g]   = mem_r_en;
        assign wd_v[g]   = mem_w_data;
        assign ma_v[g]   = mem_addr;
    end

    // Reference model: per controller, the cycle it becomes free, the cycles its
    // memory strobes and read return are due, and the values the outputs should hold.
    int            free_at [ND];
    int            w_cyc   [ND];
    int            r_cyc   [ND];
    int            rv_cyc  [ND];
    logic [AW-1:0] e_ma    [ND];
    logic [DW-1:0] e_wd    [ND];
    logic [DW-1:0] e_od    [ND];
    logic [DW-1:0] pend_rd [ND];
    logic [DW-1:0] mmem    [ND][256];
`ifdef MEM_CTRL_WBUF_EN
    logic [AW+DW-1:0] wq [ND][$];
`endif

    initial for (int d = 0; d < ND; d++) for (int i = 0; i < 256; i++) mmem[d][i] = initv(i);

    task automatic issue_write(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
        e_ma[d] = a;
        e_wd[d] = v;
        mmem[d][a[7:0]] = v;
        w_cyc[d] = cyc + 1;
        free_at[d] = cyc + 2;
    endtask

    task automatic issue_read(input int d, input logic [AW-1:0] a);
        e_ma[d] = a;
        pend_rd[d] = mmem[d][a[7:0]];
        r_cyc[d] = cyc + 1;
        rv_cyc[d] = cyc + 2 + lat(d);
        free_at[d] = cyc + 2 + lat(d);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            bit idle;
            bit pop;
            bit exp_busy;
            if (!rst_n) begin
                free_at[d] = 0; w_cyc[d] = -1; r_cyc[d] = -1; rv_cyc[d] = -1;
                e_ma[d] = '0; e_wd[d] = '0; e_od[d] = '0;
`ifdef MEM_CTRL_WBUF_EN
                wq[d].delete();
`endif
                exp_busy = 1'b0;
            end else begin
                idle = (cyc >= free_at[d]);
`ifdef MEM_CTRL_WBUF_EN
                pop = idle && (wq[d].size() > 0);
                exp_busy = wen ? (wq[d].size() == WD && !pop) : (!idle || wq[d].size() > 0);
`else
                pop = 1'b0;
                exp_busy = !idle;
`endif
                if (cyc == rv_cyc[d]) e_od[d] = pend_rd[d];
            end
            chk($sformatf("d%0d_busy", d), busy_v[d], exp_busy);
            chk($sformatf("d%0d_mem_w_en", d), we_v[d], rst_n && cyc == w_cyc[d]);
            chk($sformatf("d%0d_mem_r_en", d), re_v[d], rst_n && cyc == r_cyc[d]);
            chk($sformatf("d%0d_rvalid", d), rv_v[d], rst_n && cyc == rv_cyc[d]);
            chk($sformatf("d%0d_mem_addr", d), ma_v[d], e_ma[d]);
            chk($sformatf("d%0d_mem_w_data", d), wd_v[d], e_wd[d]);
            chk($sformatf("d%0d_o_data", d), od_v[d], e_od[d]);
            if (rst_n) begin
`ifdef MEM_CTRL_WBUF_EN
                logic [AW+DW-1:0] ent;
                if (pop) begin
                    ent = wq[d].pop_front();
                    issue_write(d, ent[AW+DW-1:DW], ent[DW-1:0]);
                end else if (ren && !wen && idle && wq[d].size() == 0) begin
                    issue_read(d, addr);
                end
                if (wen && !exp_busy) wq[d].push_back({addr, data});
`else
                if (idle && wen)      issue_write(d, addr, data);
                else if (idle && ren) issue_read(d, addr);
`endif
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(posedge clk);
        #1;
        ren = r; wen = w; addr = a; data = v;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            drive(0, 0, '0, '0);
            @(negedge clk);
            ok = !busy_v[0] && !busy_v[1] && !busy_v[2];
        end
        if (!ok) chk("wait_idle_timeout", 0, 1);
    endtask

    typedef struct {
        logic          r, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    busy, rv;
        logic          we, re;
        logic [AW-1:0] ma;
        logic [DW-1:0] wd, od;
    } vec_t;

    initial begin
        vec_t tbl [12];
        int   k;
        int   pulses;
        int   t0;

        // busy/rv columns are {lat4, lat3, lat1}; remaining columns are for the lat-1 controller.
        tbl[0]  = '{0, 1, 'h04, 'hBEEF, 3'b000, 3'b000, 0, 0, 'h00, 'h0000, 'h0000};
        tbl[1]  = '{0, 0, 'h00, 'h0000, 3'b111, 3'b000, 1, 0, 'h04, 'hBEEF, 'h0000};
        tbl[2]  = '{1, 1, 'h08, 'h1234, 3'b000, 3'b000, 0, 0, 'h04, 'hBEEF, 'h0000};
        tbl[3]  = '{1, 1, 'h08, 'h1234, 3'b111, 3'b000, 1, 0, 'h08, 'h1234, 'h0000};
        tbl[4]  = '{1, 0, 'h08, 'h0000, 3'b000, 3'b000, 0, 0, 'h08, 'h1234, 'h0000};
        tbl[5]  = '{0, 0, 'h00, 'h0000, 3'b111, 3'b000, 0, 1, 'h08, 'h1234, 'h0000};
        tbl[6]  = '{0, 0, 'h00, 'h0000, 3'b111, 3'b000, 0, 0, 'h08, 'h1234, 'h0000};
        tbl[7]  = '{0, 0, 'h00, 'h0000, 3'b110, 3'b001, 0, 0, 'h08, 'h1234, 'h1234};
        tbl[8]  = '{0, 0, 'h00, 'h0000, 3'b110, 3'b000, 0, 0, 'h08, 'h1234, 'h1234};
        tbl[9]  = '{0, 0, 'h00, 'h0000, 3'b100, 3'b010, 0, 0, 'h08, 'h1234, 'h1234};
        tbl[10] = '{0, 0, 'h00, 'h0000, 3'b000, 3'b100, 0, 0, 'h08, 'h1234, 'h1234};
        tbl[11] = '{0, 0, 'h00, 'h0000, 3'b000, 3'b000, 0, 0, 'h08, 'h1234, 'h1234};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

`ifndef MEM_CTRL_WBUF_EN
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", i), {busy_v[2], busy_v[1], busy_v[0]}, tbl[i].busy);
            chk($sformatf("tbl%0d_rvalid", i), {rv_v[2], rv_v[1], rv_v[0]}, tbl[i].rv);
            chk($sformatf("tbl%0d_mem_w_en", i), we_v[0], tbl[i].we);
            chk($sformatf("tbl%0d_mem_r_en", i), re_v[0], tbl[i].re);
            chk($sformatf("tbl%0d_mem_addr", i), ma_v[0], tbl[i].ma);
            chk($sformatf("tbl%0d_mem_w_data", i), wd_v[0], tbl[i].wd);
            chk($sformatf("tbl%0d_o_data", i), od_v[0], tbl[i].od);
        end
`endif

        // Reset while the latency-3 controller is waiting on memory.
        wait_idle();
        drive(1, 0, 'h10, '0);
        drive(0, 0, '0, '0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy_v[1], 0);
        chk("rst_mid_rvalid", rv_v[1], 0);
        chk("rst_mid_o_data", od_v[1], 0);
        chk("rst_mid_mem_addr", ma_v[1], 0);
        chk("rst_mid_mem_r_en", re_v[1], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            drive(0, 0, '0, '0);
            @(negedge clk);
            pulses += int'(rv_v[1]);
        end
        chk("rst_no_stale_rvalid", pulses, 0);
        drive(1, 0, 'h10, '0);
        @(negedge clk);
        t0 = cyc;
        for (k = 0; k < 20; k++) begin
            drive(0, 0, '0, '0);
            @(negedge clk);
            if (rv_v[1]) break;
        end
        chk("rst_after_rd_latency", cyc - t0, 5);
        chk("rst_after_rd_data", od_v[1], initv('h10));

        // Random traffic; the model checks every controller every cycle.
        repeat (400) begin
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                  AW'($urandom_range(0, 31)), DW'($urandom));
        end

`ifdef MEM_CTRL_WBUF_EN
        // Fill the FIFO behind a latency-4 read so the fifth write sees a full buffer.
        wait_idle();
        drive(1, 0, 'h40, '0);
        for (int j = 0; j < 5; j++) begin
            drive(0, 1, AW'('h41 + j), DW'('hC000 + j));
            @(negedge clk);
        end
        chk("wbuf_full_busy", busy_v[2], 1);
        for (int h = 0; h < 10 && busy_v[2]; h++) begin
            drive(0, 1, 'h45, 'hC004);
            @(negedge clk);
        end
        chk("wbuf_full_release", busy_v[2], 0);
        wait_idle();
        drive(0, 1, 'h20, 'hAAAA);
        for (k = 0; k < 30; k++) begin
            drive(1, 0, 'h20, '0);
            @(negedge clk);
            if (rv_v[0]) break;
        end
        chk("raw_rvalid_seen", rv_v[0], 1);
        chk("raw_o_data", od_v[0], 'hAAAA);
`endif

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Registered, parametrised memory access controller between the core's load/store port and the chip-top synchronous memory. It replaces the pass-through controller with a request/busy handshake, registered memory-side outputs, a configurable memory read latency and a read-data valid strobe. An optional posted-write buffer lets stores complete without stalling the core.

## Interface
- DATA_WIDTH, default `DATA_WIDTH: data bus width.
- ADDR_WIDTH, default `DATA_WIDTH: address bus width.
- RD_LATENCY, default 1: memory cycles from the mem_r_en cycle to the mem_r_data valid cycle; legal range 1..8.
- WBUF_DEPTH, default 4: posted-write FIFO entries, power of two ≥2; used only with MEM_CTRL_WBUF_EN.
- clk  in  1  clock; all flops rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_ren  in  1  read request.
- i_wen  in  1  write request.
- i_address  in  ADDR_WIDTH  request address.
- i_data  in  DATA_WIDTH  write data.
- o_busy  out  1  request not accepted this cycle; requester holds its request.
- o_data  out  DATA_WIDTH  last read data; held until the next read completes.
- o_rvalid  out  1  one-cycle pulse: o_data updated.
- mem_r_data  in  DATA_WIDTH  memory read data.
- mem_w_data  out  DATA_WIDTH  memory write data, registered.
- mem_addr  out  ADDR_WIDTH  memory address, registered.
- mem_r_en  out  1  memory read enable, registered, one-cycle pulse.
- mem_w_en  out  1  memory write enable, registered, one-cycle pulse.

## Operation
- Accept = (i_ren | i_wen) & !o_busy, sampled at the rising edge.
- i_ren and i_wen together: write wins; the read is not accepted and must be re-presented (o_busy does not flag it).
- FSM states: IDLE, WRITE, READ, WAIT.
- IDLE: accepted write -> WRITE; accepted read -> READ; otherwise stay.
- WRITE: mem_w_en=1 with registered address/data; -> IDLE.
- READ: mem_r_en=1 with registered address; load latency counter with RD_LATENCY; -> WAIT.
- WAIT: decrement counter; at zero capture mem_r_data into o_data, pulse o_rvalid; -> IDLE.
- Without buffer: o_busy = (state != IDLE).
- mem_addr/mem_w_data hold their last value when enables are low.
- Reset (any time, including mid-read): state IDLE, counter 0, buffer emptied, in-flight read discarded with no o_rvalid; o_busy, o_rvalid, o_data, mem_addr, mem_w_data, mem_r_en, mem_w_en all 0.

## Timing
- Write accepted in cycle T: mem_w_en high in T+1; next request accepted no earlier than T+2.
- Read accepted in cycle T: mem_r_en high in T+1; mem_r_data sampled at end of T+1+RD_LATENCY; o_rvalid high and new o_data in T+2+RD_LATENCY; o_busy high T+1 .. T+1+RD_LATENCY; next request accepted in T+2+RD_LATENCY.
- Read throughput: one per RD_LATENCY+2 cycles. o_rvalid never asserts twice back-to-back.

## Configuration
- MEM_CTRL_WBUF_EN defined: writes enter a WBUF_DEPTH FIFO (address+data). For a write, o_busy = FIFO full; for a read, o_busy = (state != IDLE) | FIFO non-empty, so reads always observe prior writes. In IDLE with FIFO non-empty the FSM pops one entry -> WRITE; this drain has priority over a pending read. Push and pop in the same cycle when full is allowed only if the pop occurs; the pointers wrap modulo WBUF_DEPTH.
- Not defined: no FIFO; writes handled directly by the FSM as above; WBUF_DEPTH ignored.

## Test plan
- Reset mid-read: RD_LATENCY=3, read addr 0x10 accepted, rst_n low in WAIT -> all outputs 0, no o_rvalid after release, next read completes normally.
- Single write: addr 0x04, data 0xBEEF at T -> mem_w_en=1, mem_addr=0x04, mem_w_data=0xBEEF in T+1 only; o_busy high in T+1.
- Read latency sweep: RD_LATENCY=1 and 4, memory model returns 0x1234 -> o_rvalid at T+3 and T+6 respectively, o_data=0x1234 and held afterwards.
- Simultaneous i_ren/i_wen to 0x08 -> only the write issues; read issues after re-presentation.
- Buffer (MEM_CTRL_WBUF_EN, depth 4): 5 back-to-back writes -> o_busy on the 5th until one drains; all five reach memory in order.
- Read-after-write with buffer: write 0x20=0xAAAA then read 0x20 -> read held busy until FIFO empty; mem_r_en follows the last mem_w_en; o_data=0xAAAA.
